snitch_icache_miss_handler: RTL and testbench
=============================================

Name: snitch_icache_miss_handler

Overview:
- Sits directly downstream of the L1 lookup stage and consumes its result stream (addr, id, set, hit, data, error).
- Hits are returned to the fetch ports through a one-entry response register.
- Misses allocate or merge into a pending-refill table and issue line refill requests to L2.
- Returning refill lines are written back into the lookup stage's write port and broadcast to every waiting fetch port.

Parameters:
- FETCH_AW, 32, fetch address width.
- ID_WIDTH, 2, fetch-port ID width; IDs are one-hot, one bit per fetch port.
- LINE_WIDTH, 128, cache line width in bits.
- LINE_ALIGN, 4, log2 of line size in bytes.
- COUNT_ALIGN, 5, log2 of lines per way.
- SET_ALIGN, 1, log2 of way count.
- PENDING_COUNT, 2, number of pending-refill table entries.
- Derived: TAG_WIDTH = FETCH_AW-LINE_ALIGN-COUNT_ALIGN; PIDW = max(1,$clog2(PENDING_COUNT)).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- in_addr_i  in  FETCH_AW  looked-up fetch address
- in_id_i  in  ID_WIDTH  one-hot requester
- in_set_i  in  SET_ALIGN  hit way (unused here, kept for debug)
- in_hit_i  in  1  lookup hit
- in_data_i  in  LINE_WIDTH  hit line data
- in_error_i  in  1  hit line error flag
- in_valid_i  in  1  lookup result valid
- in_ready_o  out  1  result accepted
- rsp_data_o  out  LINE_WIDTH  line to fetch ports
- rsp_error_o  out  1  line error
- rsp_id_o  out  ID_WIDTH  mask of recipient fetch ports
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response accepted
- refill_req_addr_o  out  FETCH_AW  line-aligned refill address
- refill_req_id_o  out  PIDW  pending-table index
- refill_req_valid_o  out  1  refill request valid
- refill_req_ready_i  in  1  refill request accepted
- refill_rsp_data_i  in  LINE_WIDTH  returned line
- refill_rsp_error_i  in  1  returned line error
- refill_rsp_id_i  in  PIDW  pending-table index
- refill_rsp_valid_i  in  1  refill response valid
- refill_rsp_ready_o  out  1  refill response accepted
- write_addr_o  out  COUNT_ALIGN  line index to write
- write_set_o  out  SET_ALIGN  way to write
- write_data_o  out  LINE_WIDTH  line data
- write_tag_o  out  TAG_WIDTH  tag
- write_error_o  out  1  error bit
- write_valid_o  out  1  write valid
- write_ready_i  in  1  write accepted

Behaviour:
- Reset (rst_i high at a clock edge) clears:
  - all table entries;
  - the response register: rsp_valid_o=0;
  - the refill request register: refill_req_valid_o=0;
  - the completion register: write_valid_o=0, refill_rsp_ready_o=1;
  - the way counter to 0.
- Reset mid-operation discards all in-flight state.
- Table entry fields: valid, line address (FETCH_AW-LINE_ALIGN bits), waiter mask (ID_WIDTH), returning flag.

Completion register (one entry):
- A refill response is captured when refill_rsp_ready_o=1, where refill_rsp_ready_o = completion register empty.
- The entry's returning flag is set on capture.
- If refill_rsp_id_i names an invalid entry, the response is accepted and discarded.
- The next cycle drives write_valid_o, with:
  - write_addr_o = addr[LINE_ALIGN +: COUNT_ALIGN];
  - write_tag_o = addr[FETCH_AW-1 : LINE_ALIGN+COUNT_ALIGN];
  - write_set_o = way counter.
- On the same cycle, the response register is loaded with data, error and the waiter mask once it is empty or draining. Refill completion has priority over the hit path.
- Write and response handshakes are tracked by separate done flags.
- When both are done, the entry is freed and the completion register empties. Earliest refill_rsp_ready_o reassertion is the following cycle.
- The way counter increments (wrapping) on every write handshake.

Input handling, evaluated in priority order with in_valid_i high:
1. Completion wants the response register this cycle: in_ready_o=0.
2. Hit: accept when the response register is empty or rsp_ready_i=1. Load data/error/id; latency 1 cycle to rsp_valid_o.
3. Miss matching a valid, non-returning entry's line: OR in_id_i into its mask. in_ready_o=1; no refill is issued.
4. Miss matching a returning entry: in_ready_o=0 until the entry is freed. The request is then handled by rule 5 (a redundant refill is acceptable).
5. Miss otherwise: requires a free entry and an empty refill request register.
   - Allocate the lowest free index.
   - Store line address and id.
   - Drive refill_req_valid_o next cycle, with the address's low LINE_ALIGN bits zeroed.
   - If either resource is unavailable, in_ready_o=0.

Handshakes and simultaneous events:
- All outputs hold stable while valid && !ready.
- Simultaneous allocation and free of the same index in one cycle is not allowed; the freed entry becomes allocatable the next cycle.
- A refill response may return for an entry whose request handshake occurred in the same cycle as capture.

Test Plan:
- Hit addr 0x1040, id 2'b01, data 0xA5.., rsp_ready_i=1 → next cycle rsp_valid_o=1, rsp_id_o=01, data 0xA5..; no refill request.
- Miss 0x2008 id 01 → refill_req_addr_o=0x2000, refill_req_id_o=0. Respond with data D → write_addr_o=0, write_tag_o=0x2000>>9, write_set_o=0; response id 01; way counter becomes 1.
- Miss 0x3000 id 01, then miss 0x3004 id 10 before the refill returns → a single refill request; final rsp_id_o=11.
- PENDING_COUNT=2, three distinct-line misses → third stalls (in_ready_o=0) until the first refill's write and response both complete.
- Refill completion pending while a hit arrives, rsp_ready_i=0 for 3 cycles → refill line delivered first, hit stalled, then delivered; nothing lost.
- Assert rst_i during an outstanding refill, then return refill_rsp_id_i=0 → accepted and discarded; no write_valid_o, no rsp_valid_o.

Source files
------------

// File: rtl/snitch_icache_miss_handler.sv
// Instruction cache miss handler: returns lookup hits, tracks outstanding line
// refills in a small pending table and writes returning lines back to the cache.
module snitch_icache_miss_handler #(
  parameter int FETCH_AW      = 32,
  parameter int ID_WIDTH      = 2,
  parameter int LINE_WIDTH    = 128,
  parameter int LINE_ALIGN    = 4,
  parameter int COUNT_ALIGN   = 5,
  parameter int SET_ALIGN     = 1,
  parameter int PENDING_COUNT = 2,
  localparam int TAG_WIDTH    = FETCH_AW - LINE_ALIGN - COUNT_ALIGN,
  localparam int PIDW         = (PENDING_COUNT > 1) ? $clog2(PENDING_COUNT) : 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [FETCH_AW-1:0]    in_addr_i,
  input  logic [ID_WIDTH-1:0]    in_id_i,
  input  logic [SET_ALIGN-1:0]   in_set_i,
  input  logic                   in_hit_i,
  input  logic [LINE_WIDTH-1:0]  in_data_i,
  input  logic                   in_error_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic [LINE_WIDTH-1:0]  rsp_data_o,
  output logic                   rsp_error_o,
  output logic [ID_WIDTH-1:0]    rsp_id_o,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [FETCH_AW-1:0]    refill_req_addr_o,
  output logic [PIDW-1:0]        refill_req_id_o,
  output logic                   refill_req_valid_o,
  input  logic                   refill_req_ready_i,
  input  logic [LINE_WIDTH-1:0]  refill_rsp_data_i,
  input  logic                   refill_rsp_error_i,
  input  logic [PIDW-1:0]        refill_rsp_id_i,
  input  logic                   refill_rsp_valid_i,
  output logic                   refill_rsp_ready_o,
  output logic [COUNT_ALIGN-1:0] write_addr_o,
  output logic [SET_ALIGN-1:0]   write_set_o,
  output logic [LINE_WIDTH-1:0]  write_data_o,
  output logic [TAG_WIDTH-1:0]   write_tag_o,
  output logic                   write_error_o,
  output logic                   write_valid_o,
  input  logic                   write_ready_i
);

  localparam int LAW = FETCH_AW - LINE_ALIGN;

  logic [PENDING_COUNT-1:0] tbl_valid, tbl_ret;
  logic [LAW-1:0]           tbl_addr [PENDING_COUNT];
  logic [ID_WIDTH-1:0]      tbl_mask [PENDING_COUNT];

  logic                  cmp_valid, cmp_wr_done, cmp_rsp_done, cmp_error;
  logic [PIDW-1:0]       cmp_idx;
  logic [LINE_WIDTH-1:0] cmp_data;
  logic [SET_ALIGN-1:0]  way_q;

  logic [LAW-1:0]           in_line;
  logic [PENDING_COUNT-1:0] match_pend;
  logic                     match_pend_any, match_ret_any, free_found;
  logic [PIDW-1:0]          free_idx;
  logic write_fire, rsp_free, cmp_wants_rsp, rsp_load, cmp_finish;
  logic hit_ok, merge_ok, alloc_ok;
  logic hit_fire, merge_fire, alloc_fire, rr_keep;
  logic unused_in;

  assign unused_in = ^{in_set_i, in_addr_i[LINE_ALIGN-1:0]};
  assign in_line   = in_addr_i[FETCH_AW-1:LINE_ALIGN];

  always_comb begin
    match_pend     = '0;
    match_pend_any = 1'b0;
    match_ret_any  = 1'b0;
    free_found     = 1'b0;
    free_idx       = '0;
    for (int i = 0; i < PENDING_COUNT; i++) begin
      if (tbl_valid[i] && tbl_addr[i] == in_line) begin
        if (tbl_ret[i]) match_ret_any = 1'b1;
        else begin
          match_pend[i]  = 1'b1;
          match_pend_any = 1'b1;
        end
      end
    end
    // Scan downwards so the lowest free index wins.
    for (int i = PENDING_COUNT - 1; i >= 0; i--) begin
      if (!tbl_valid[i]) begin
        free_found = 1'b1;
        free_idx   = PIDW'(i);
      end
    end
  end

  assign write_valid_o      = cmp_valid && !cmp_wr_done;
  assign refill_rsp_ready_o = !cmp_valid;
  assign write_fire         = write_valid_o && write_ready_i;
  assign rsp_free           = !rsp_valid_o || rsp_ready_i;
  assign cmp_wants_rsp      = cmp_valid && !cmp_rsp_done;
  assign rsp_load           = cmp_wants_rsp && rsp_free;
  assign cmp_finish         = cmp_valid && (cmp_wr_done || write_fire) && (cmp_rsp_done || rsp_load);

  // A miss on a line that is already being written back waits until the entry is freed.
  assign hit_ok   = !cmp_wants_rsp && in_hit_i && rsp_free;
  assign merge_ok = !cmp_wants_rsp && !in_hit_i && match_pend_any;
  assign alloc_ok = !cmp_wants_rsp && !in_hit_i && !match_pend_any && !match_ret_any
                    && free_found && !refill_req_valid_o;

  assign in_ready_o = hit_ok || merge_ok || alloc_ok;
  assign hit_fire   = in_valid_i && hit_ok;
  assign merge_fire = in_valid_i && merge_ok;
  assign alloc_fire = in_valid_i && alloc_ok;
  assign rr_keep    = refill_rsp_valid_i && !cmp_valid && tbl_valid[refill_rsp_id_i];

  assign write_addr_o  = tbl_addr[cmp_idx][COUNT_ALIGN-1:0];
  assign write_tag_o   = tbl_addr[cmp_idx][LAW-1:COUNT_ALIGN];
  assign write_set_o   = way_q;
  assign write_data_o  = cmp_data;
  assign write_error_o = cmp_error;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      tbl_valid          <= '0;
      tbl_ret            <= '0;
      for (int i = 0; i < PENDING_COUNT; i++) begin
        tbl_addr[i] <= '0;
        tbl_mask[i] <= '0;
      end
      cmp_valid          <= 1'b0;
      cmp_wr_done        <= 1'b0;
      cmp_rsp_done       <= 1'b0;
      cmp_idx            <= '0;
      cmp_data           <= '0;
      cmp_error          <= 1'b0;
      way_q              <= '0;
      rsp_valid_o        <= 1'b0;
      rsp_data_o         <= '0;
      rsp_error_o        <= 1'b0;
      rsp_id_o           <= '0;
      refill_req_valid_o <= 1'b0;
      refill_req_addr_o  <= '0;
      refill_req_id_o    <= '0;
    end else begin
      if (rr_keep) begin
        cmp_valid                <= 1'b1;
        cmp_idx                  <= refill_rsp_id_i;
        cmp_data                 <= refill_rsp_data_i;
        cmp_error                <= refill_rsp_error_i;
        cmp_wr_done              <= 1'b0;
        cmp_rsp_done             <= 1'b0;
        tbl_ret[refill_rsp_id_i] <= 1'b1;
      end else if (cmp_finish) begin
        cmp_valid          <= 1'b0;
        tbl_valid[cmp_idx] <= 1'b0;
        tbl_ret[cmp_idx]   <= 1'b0;
      end else begin
        if (write_fire) cmp_wr_done  <= 1'b1;
        if (rsp_load)   cmp_rsp_done <= 1'b1;
      end

      if (write_fire) way_q <= way_q + SET_ALIGN'(1);

      if (rsp_load) begin
        rsp_valid_o <= 1'b1;
        rsp_data_o  <= cmp_data;
        rsp_error_o <= cmp_error;
        rsp_id_o    <= tbl_mask[cmp_idx];
      end else if (hit_fire) begin
        rsp_valid_o <= 1'b1;
        rsp_data_o  <= in_data_i;
        rsp_error_o <= in_error_i;
        rsp_id_o    <= in_id_i;
      end else if (rsp_ready_i) begin
        rsp_valid_o <= 1'b0;
      end

      for (int i = 0; i < PENDING_COUNT; i++) begin
        if (merge_fire && match_pend[i]) tbl_mask[i] <= tbl_mask[i] | in_id_i;
      end

      if (alloc_fire) begin
        tbl_valid[free_idx] <= 1'b1;
        tbl_ret[free_idx]   <= 1'b0;
        tbl_addr[free_idx]  <= in_line;
        tbl_mask[free_idx]  <= in_id_i;
        refill_req_valid_o  <= 1'b1;
        refill_req_addr_o   <= {in_line, {LINE_ALIGN{1'b0}}};
        refill_req_id_o     <= free_idx;
      end else if (refill_req_ready_i) begin
        refill_req_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_snitch_icache_miss_handler.sv
// Directed bench for the icache miss handler: a hit-path vector table followed
// by hand-written miss, merge, table-full, contention and reset sequences.
module tb_snitch_icache_miss_handler;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [31:0]  in_addr = '0;
  logic [1:0]   in_id = '0;
  logic [0:0]   in_set = '0;
  logic         in_hit = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_error = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready_o;
  logic [127:0] rsp_data_o;
  logic         rsp_error_o;
  logic [1:0]   rsp_id_o;
  logic         rsp_valid_o;
  logic         rsp_ready = 1'b1;
  logic [31:0]  refill_req_addr_o;
  logic [0:0]   refill_req_id_o;
  logic         refill_req_valid_o;
  logic         refill_req_ready = 1'b1;
  logic [127:0] rr_data = '0;
  logic         rr_error = 1'b0;
  logic [0:0]   rr_id = '0;
  logic         rr_valid = 1'b0;
  logic         refill_rsp_ready_o;
  logic [4:0]   write_addr_o;
  logic [0:0]   write_set_o;
  logic [127:0] write_data_o;
  logic [22:0]  write_tag_o;
  logic         write_error_o;
  logic         write_valid_o;
  logic         write_ready = 1'b1;

  always #5 clk = ~clk;

  snitch_icache_miss_handler dut (
    .clk_i(clk), .rst_i(rst),
    .in_addr_i(in_addr), .in_id_i(in_id), .in_set_i(in_set), .in_hit_i(in_hit),
    .in_data_i(in_data), .in_error_i(in_error), .in_valid_i(in_valid), .in_ready_o(in_ready_o),
    .rsp_data_o(rsp_data_o), .rsp_error_o(rsp_error_o), .rsp_id_o(rsp_id_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .refill_req_addr_o(refill_req_addr_o), .refill_req_id_o(refill_req_id_o),
    .refill_req_valid_o(refill_req_valid_o), .refill_req_ready_i(refill_req_ready),
    .refill_rsp_data_i(rr_data), .refill_rsp_error_i(rr_error), .refill_rsp_id_i(rr_id),
    .refill_rsp_valid_i(rr_valid), .refill_rsp_ready_o(refill_rsp_ready_o),
    .write_addr_o(write_addr_o), .write_set_o(write_set_o), .write_data_o(write_data_o),
    .write_tag_o(write_tag_o), .write_error_o(write_error_o), .write_valid_o(write_valid_o),
    .write_ready_i(write_ready)
  );

  typedef struct packed {logic [1:0] id; logic err; logic [127:0] data;} rsp_t;
  typedef struct packed {logic [4:0] addr; logic [22:0] tag; logic set; logic err; logic [127:0] data;} wr_t;
  typedef struct packed {logic [31:0] addr; logic id;} req_t;

  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  req_t req_q[$];

  // Handshake monitors, sampled mid-cycle while inputs are stable.
  always @(negedge clk) begin
    if (!rst) begin
      if (rsp_valid_o && rsp_ready) rsp_q.push_back({rsp_id_o, rsp_error_o, rsp_data_o});
      if (write_valid_o && write_ready)
        wr_q.push_back({write_addr_o, write_tag_o, write_set_o[0], write_error_o, write_data_o});
      if (refill_req_valid_o && refill_req_ready) req_q.push_back({refill_req_addr_o, refill_req_id_o[0]});
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic clear_q();
    rsp_q.delete(); wr_q.delete(); req_q.delete();
  endtask

  task automatic send(input logic [31:0] a, input logic [1:0] id, input logic hit, input logic [127:0] d);
    int n = 0;
    in_addr = a; in_id = id; in_hit = hit; in_data = d; in_error = 1'b0; in_valid = 1'b1;
    #1;
    while (!in_ready_o && n < 50) begin @(posedge clk); #2; n++; end
    chk("send_ready", in_ready_o, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic give_refill(input logic [0:0] id, input logic [127:0] d, input logic e);
    int n = 0;
    rr_id = id; rr_data = d; rr_error = e; rr_valid = 1'b1;
    #1;
    while (!refill_rsp_ready_o && n < 50) begin @(posedge clk); #2; n++; end
    chk("refill_rsp_ready", refill_rsp_ready_o, 1);
    @(posedge clk); #1;
    rr_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int k);
    for (int n = 0; n < 60 && rsp_q.size() < k; n++) cyc();
    chk("rsp_count", rsp_q.size(), k);
  endtask

  task automatic wait_wr(input int k);
    for (int n = 0; n < 60 && wr_q.size() < k; n++) cyc();
    chk("write_count", wr_q.size(), k);
  endtask

  task automatic wait_req(input int k);
    for (int n = 0; n < 60 && req_q.size() < k; n++) cyc();
    chk("req_count", req_q.size(), k);
  endtask

  typedef struct {
    logic vld; logic [31:0] addr; logic [1:0] id; logic [127:0] data; logic err; logic rdy;
    logic exp_in_ready; logic exp_v; logic [1:0] exp_id; logic [127:0] exp_data; logic exp_err;
  } vec_t;

  vec_t vt[7];

  initial begin
    logic [127:0] da5, d5a, d3c, d77;
    da5 = {4{32'hA5A5A5A5}}; d5a = {4{32'h5A5A5A5A}};
    d3c = {4{32'h3C3C3C3C}}; d77 = {4{32'h77777777}};
    //        vld addr         id     data err rdy  in_rdy v  id     data err
    vt[0] = '{1, 32'h0000_1040, 2'b01, da5, 0, 1,   1,     1, 2'b01, da5, 0};
    vt[1] = '{1, 32'h0000_1050, 2'b10, d5a, 1, 0,   0,     1, 2'b01, da5, 0};
    vt[2] = '{1, 32'h0000_1050, 2'b10, d5a, 1, 1,   1,     1, 2'b10, d5a, 1};
    vt[3] = '{0, 32'h0000_0000, 2'b00, '0,  0, 1,   0,     0, 2'b00, '0,  0};
    vt[4] = '{1, 32'h0000_2200, 2'b01, d3c, 0, 0,   1,     1, 2'b01, d3c, 0};
    vt[5] = '{1, 32'h0000_2210, 2'b10, d77, 0, 0,   0,     1, 2'b01, d3c, 0};
    vt[6] = '{0, 32'h0000_0000, 2'b00, '0,  0, 1,   0,     0, 2'b00, '0,  0};

    repeat (3) cyc();
    rst = 1'b0;
    #1;
    chk("reset_rsp_valid", rsp_valid_o, 0);
    chk("reset_req_valid", refill_req_valid_o, 0);
    chk("reset_write_valid", write_valid_o, 0);
    chk("reset_refill_rsp_ready", refill_rsp_ready_o, 1);
    cyc();

    // Hit path table
    for (int i = 0; i < 7; i++) begin
      in_valid = vt[i].vld; in_addr = vt[i].addr; in_id = vt[i].id; in_hit = 1'b1;
      in_data = vt[i].data; in_error = vt[i].err; rsp_ready = vt[i].rdy;
      #1;
      if (vt[i].vld) chk("tbl_in_ready", in_ready_o, vt[i].exp_in_ready);
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("tbl_rsp_valid", rsp_valid_o, vt[i].exp_v);
      if (vt[i].exp_v) begin
        chk("tbl_rsp_id", rsp_id_o, vt[i].exp_id);
        chk("tbl_rsp_data", rsp_data_o, vt[i].exp_data);
        chk("tbl_rsp_error", rsp_error_o, vt[i].exp_err);
      end
      chk("tbl_no_req", refill_req_valid_o, 0);
    end
    rsp_ready = 1'b1;
    cyc();
    clear_q();

    // Single miss and refill
    send(32'h2008, 2'b01, 1'b0, '0);
    wait_req(1);
    chk("b_req_addr", req_q[0].addr, 32'h2000);
    chk("b_req_id", req_q[0].id, 0);
    give_refill(1'b0, {4{32'hD00D0001}}, 1'b0);
    wait_wr(1); wait_rsp(1);
    chk("b_wr_addr", wr_q[0].addr, 0);
    chk("b_wr_tag", wr_q[0].tag, 23'h10);
    chk("b_wr_set", wr_q[0].set, 0);
    chk("b_wr_data", wr_q[0].data, {4{32'hD00D0001}});
    chk("b_rsp_id", rsp_q[0].id, 2'b01);
    chk("b_rsp_data", rsp_q[0].data, {4{32'hD00D0001}});
    clear_q();

    // Two misses to the same line merge into one refill
    send(32'h3000, 2'b01, 1'b0, '0);
    send(32'h3004, 2'b10, 1'b0, '0);
    wait_req(1);
    repeat (4) cyc();
    chk("c_single_req", req_q.size(), 1);
    chk("c_req_addr", req_q[0].addr, 32'h3000);
    give_refill(1'b0, {4{32'hC0DE0002}}, 1'b1);
    wait_wr(1); wait_rsp(1);
    chk("c_rsp_id", rsp_q[0].id, 2'b11);
    chk("c_rsp_err", rsp_q[0].err, 1);
    chk("c_wr_set", wr_q[0].set, 1);
    chk("c_wr_tag", wr_q[0].tag, 23'h18);
    clear_q();

    // Table full: third distinct miss waits for write and response of the first
    send(32'h4000, 2'b01, 1'b0, '0);
    send(32'h5000, 2'b01, 1'b0, '0);
    wait_req(2);
    chk("d_req0_id", req_q[0].id, 0);
    chk("d_req1_id", req_q[1].id, 1);
    chk("d_req1_addr", req_q[1].addr, 32'h5000);
    write_ready = 1'b0;
    in_addr = 32'h6000; in_id = 2'b10; in_hit = 1'b0; in_valid = 1'b1;
    #1;
    chk("d_stall_full", in_ready_o, 0);
    give_refill(1'b0, {4{32'hDD000000}}, 1'b0);
    repeat (3) begin
      #1; chk("d_stall_write", in_ready_o, 0);
      @(posedge clk); #1;
    end
    write_ready = 1'b1;
    begin
      int n = 0;
      #1;
      while (!in_ready_o && n < 20) begin @(posedge clk); #2; n++; end
      chk("d_stall_release", in_ready_o, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    wait_req(3);
    chk("d_req2_addr", req_q[2].addr, 32'h6000);
    chk("d_req2_id", req_q[2].id, 0);
    give_refill(1'b1, {4{32'hDD111111}}, 1'b0);
    give_refill(1'b0, {4{32'hDD222222}}, 1'b0);
    wait_rsp(3); wait_wr(3);
    chk("d_rsp0_id", rsp_q[0].id, 2'b01);
    chk("d_rsp1_data", rsp_q[1].data, {4{32'hDD111111}});
    chk("d_rsp2_id", rsp_q[2].id, 2'b10);
    chk("d_rsp2_data", rsp_q[2].data, {4{32'hDD222222}});
    chk("d_wr_set0", wr_q[0].set, 0);
    chk("d_wr_set1", wr_q[1].set, 1);
    chk("d_wr_set2", wr_q[2].set, 0);
    clear_q();

    // Refill completion wins the response register over a concurrent hit
    send(32'h7000, 2'b01, 1'b0, '0);
    wait_req(1);
    rsp_ready = 1'b0;
    give_refill(1'b0, {4{32'hEE000007}}, 1'b0);
    in_addr = 32'h1040; in_id = 2'b10; in_hit = 1'b1; in_data = {4{32'h11112222}}; in_valid = 1'b1;
    #1;
    chk("e_hit_blocked_cmp", in_ready_o, 0);
    @(posedge clk); #1;
    repeat (3) begin
      #1;
      chk("e_hit_blocked_rsp", in_ready_o, 0);
      chk("e_rsp_hold", rsp_data_o, {4{32'hEE000007}});
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    #1;
    chk("e_hit_accept", in_ready_o, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_rsp(2);
    chk("e_rsp0_data", rsp_q[0].data, {4{32'hEE000007}});
    chk("e_rsp0_id", rsp_q[0].id, 2'b01);
    chk("e_rsp1_data", rsp_q[1].data, {4{32'h11112222}});
    chk("e_rsp1_id", rsp_q[1].id, 2'b10);
    chk("e_wr_set", wr_q[0].set, 1);
    clear_q();

    // Reset mid-refill discards the entry and the way counter
    send(32'h9000, 2'b01, 1'b0, '0);
    wait_req(1);
    give_refill(1'b0, {4{32'h99999999}}, 1'b0);
    wait_wr(1); wait_rsp(1);
    chk("f_wr_set_pre", wr_q[0].set, 0);
    clear_q();
    send(32'h8000, 2'b01, 1'b0, '0);
    wait_req(1);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    chk("f_rst_rsp_valid", rsp_valid_o, 0);
    chk("f_rst_write_valid", write_valid_o, 0);
    chk("f_rst_req_valid", refill_req_valid_o, 0);
    chk("f_rst_refill_rsp_ready", refill_rsp_ready_o, 1);
    clear_q();
    cyc();
    give_refill(1'b0, {4{32'hBADBAD00}}, 1'b0);
    repeat (5) cyc();
    chk("f_discard_write", wr_q.size(), 0);
    chk("f_discard_rsp", rsp_q.size(), 0);
    send(32'h2008, 2'b10, 1'b0, '0);
    wait_req(1);
    chk("f_req_id", req_q[0].id, 0);
    give_refill(1'b0, {4{32'h600D600D}}, 1'b0);
    wait_wr(1); wait_rsp(1);
    chk("f_way_after_reset", wr_q[0].set, 0);
    chk("f_rsp_id", rsp_q[0].id, 2'b10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
